// File: rtl/ram_arbiter_pkg.sv
// Shared peripheral defines for the RAM arbiter: FSM encoding, master port IDs,
// the data returned on a read timeout, and the latched RAM command record.
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_RDATA = 2'd2
   } arb_state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LSU   = 1'b1;

   localparam logic [31:0] TIMEOUT_DATA = 32'h0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] write_data;
      logic        read_en;
      logic        write_en;
      logic [3:0]  byte_en;
   } ram_cmd_t;

endpackage

// File: rtl/ram_arbiter_rr_arbiter_2.sv
// Two-request round-robin grant: a lone request wins, a tie goes to the port
// that did not win last time.
module rr_arbiter_2
   import ram_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant
);

   always_comb begin
      grant_valid = req0 | req1;
      grant       = PORT_FETCH;
      if (req0 && req1) begin
         grant = ~last_grant;
      end else if (req1) begin
         grant = PORT_LSU;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported peripheral RAM between fetch (m0) and LSU (m1):
// one request at a time is latched, replayed to the RAM and its read data routed back.
//
// state         | meaning
// ST_IDLE       | no transaction; grant offered to the winning master
// ST_ISSUE      | latched command presented to RAM until ram_ready_in
// ST_WAIT_RDATA | read issued; waiting for ram_rdata_valid_in or timeout
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned RDATA_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid_in,
   output logic        m0_ready_out,
   input  logic [31:0] m0_addr_in,
   input  logic [31:0] m0_write_data_in,
   input  logic        m0_read_en_in,
   input  logic        m0_write_en_in,
   input  logic [3:0]  m0_write_byte_en_in,
   output logic        m0_rdata_valid_out,
   output logic [31:0] m0_read_data_out,
   input  logic        m1_valid_in,
   output logic        m1_ready_out,
   input  logic [31:0] m1_addr_in,
   input  logic [31:0] m1_write_data_in,
   input  logic        m1_read_en_in,
   input  logic        m1_write_en_in,
   input  logic [3:0]  m1_write_byte_en_in,
   output logic        m1_rdata_valid_out,
   output logic [31:0] m1_read_data_out,
   output logic        bus_err_out,
   output logic        ram_valid_out,
   input  logic        ram_ready_in,
   output logic [31:0] ram_addr_out,
   output logic [31:0] ram_write_data_out,
   output logic        ram_read_en_out,
   output logic        ram_write_en_out,
   output logic [3:0]  ram_write_byte_en_out,
   input  logic        ram_rdata_valid_in,
   input  logic [31:0] ram_read_data_in
);

   arb_state_t  state, state_nxt;
   ram_cmd_t    cmd, m0_cmd, m1_cmd;
   logic        owner, last_grant;
   logic        grant_valid, grant;
   logic        accept, ram_fire, take_data, timeout;
   logic [31:0] wait_cnt;
   logic [31:0] resp_data;

   rr_arbiter_2 u_rr (
      .req0        (m0_valid_in),
      .req1        (m1_valid_in),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign m0_cmd = {m0_addr_in, m0_write_data_in, m0_read_en_in, m0_write_en_in, m0_write_byte_en_in};
   assign m1_cmd = {m1_addr_in, m1_write_data_in, m1_read_en_in, m1_write_en_in, m1_write_byte_en_in};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ram_fire  = 1'b0;
      take_data = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_valid) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ram_ready_in) begin
               ram_fire  = 1'b1;
               state_nxt = cmd.write_en ? ST_IDLE : ST_WAIT_RDATA;
            end
         end
         ST_WAIT_RDATA: begin
            // data arriving on the last allowed cycle still wins over the timeout
            if (ram_rdata_valid_in) begin
               take_data = 1'b1;
               state_nxt = ST_IDLE;
            end else if ((RDATA_TIMEOUT != 0) && (wait_cnt + 32'd1 == RDATA_TIMEOUT)) begin
               timeout   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign resp_data = take_data ? ram_read_data_in : TIMEOUT_DATA;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd                <= '0;
         owner              <= PORT_FETCH;
         last_grant         <= PORT_LSU;
         wait_cnt           <= 32'd0;
         m0_rdata_valid_out <= 1'b0;
         m1_rdata_valid_out <= 1'b0;
         m0_read_data_out   <= 32'h0;
         m1_read_data_out   <= 32'h0;
         bus_err_out        <= 1'b0;
      end else begin
         m0_rdata_valid_out <= 1'b0;
         m1_rdata_valid_out <= 1'b0;
         bus_err_out        <= 1'b0;
         if (accept) begin
            cmd        <= (grant == PORT_LSU) ? m1_cmd : m0_cmd;
            owner      <= grant;
            last_grant <= grant;
         end
         if (ram_fire) begin
            wait_cnt <= 32'd0;
         end else if (state == ST_WAIT_RDATA) begin
            wait_cnt <= wait_cnt + 32'd1;
         end
         if (take_data || timeout) begin
            bus_err_out <= timeout;
            if (owner == PORT_LSU) begin
               m1_read_data_out   <= resp_data;
               m1_rdata_valid_out <= 1'b1;
            end else begin
               m0_read_data_out   <= resp_data;
               m0_rdata_valid_out <= 1'b1;
            end
         end
      end
   end

   assign m0_ready_out          = (state == ST_IDLE) && grant_valid && (grant == PORT_FETCH);
   assign m1_ready_out          = (state == ST_IDLE) && grant_valid && (grant == PORT_LSU);
   assign ram_valid_out         = (state == ST_ISSUE);
   assign ram_addr_out          = cmd.addr;
   assign ram_write_data_out    = cmd.write_data;
   assign ram_read_en_out       = cmd.read_en;
   assign ram_write_en_out      = cmd.write_en;
   assign ram_write_byte_en_out = cmd.byte_en;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a transaction-level model predicts grants,
// RAM command windows and response cycles; a simple RAM model answers the DUT.
module tb_ram_arbiter;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid_in, m0_ready_out, m0_read_en_in, m0_write_en_in, m0_rdata_valid_out;
   logic [31:0] m0_addr_in, m0_write_data_in, m0_read_data_out;
   logic [3:0]  m0_write_byte_en_in;
   logic        m1_valid_in, m1_ready_out, m1_read_en_in, m1_write_en_in, m1_rdata_valid_out;
   logic [31:0] m1_addr_in, m1_write_data_in, m1_read_data_out;
   logic [3:0]  m1_write_byte_en_in;
   logic        bus_err_out, ram_valid_out, ram_ready_in, ram_read_en_out, ram_write_en_out;
   logic [31:0] ram_addr_out, ram_write_data_out, ram_read_data_in;
   logic [3:0]  ram_write_byte_en_out;
   logic        ram_rdata_valid_in;

   ram_arbiter #(.RDATA_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .m0_valid_in(m0_valid_in), .m0_ready_out(m0_ready_out), .m0_addr_in(m0_addr_in),
      .m0_write_data_in(m0_write_data_in), .m0_read_en_in(m0_read_en_in),
      .m0_write_en_in(m0_write_en_in), .m0_write_byte_en_in(m0_write_byte_en_in),
      .m0_rdata_valid_out(m0_rdata_valid_out), .m0_read_data_out(m0_read_data_out),
      .m1_valid_in(m1_valid_in), .m1_ready_out(m1_ready_out), .m1_addr_in(m1_addr_in),
      .m1_write_data_in(m1_write_data_in), .m1_read_en_in(m1_read_en_in),
      .m1_write_en_in(m1_write_en_in), .m1_write_byte_en_in(m1_write_byte_en_in),
      .m1_rdata_valid_out(m1_rdata_valid_out), .m1_read_data_out(m1_read_data_out),
      .bus_err_out(bus_err_out), .ram_valid_out(ram_valid_out), .ram_ready_in(ram_ready_in),
      .ram_addr_out(ram_addr_out), .ram_write_data_out(ram_write_data_out),
      .ram_read_en_out(ram_read_en_out), .ram_write_en_out(ram_write_en_out),
      .ram_write_byte_en_out(ram_write_byte_en_out),
      .ram_rdata_valid_in(ram_rdata_valid_in), .ram_read_data_in(ram_read_data_in)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rd;
      logic        wr;
      logic [3:0]  be;
   } req_t;

   req_t        q0[$], q1[$];
   int          tests = 0, fails = 0;
   int          cyc = 0, free_cyc = 0;
   logic        pres[2];
   logic        exp_last;
   logic [31:0] ref_mem[16], ram_mem[16];
   logic [31:0] exp_rd[2];
   req_t        last_cmd;
   bit          t_valid = 0, t_wr = 0, t_drop = 0;
   logic        t_owner;
   int          t_iss_lo, t_h, t_d, t_resp;
   logic [31:0] t_rdata;
   int          stall_force = -1, lat_force = -1, drop_force = -1;
   bit          force_stray = 0, quiet = 1;
   int          gap_pct = 0;

   task automatic chk_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, want %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                               input logic r, input logic w, input logic [3:0] be);
      req_t x;
      x.addr = a; x.data = d; x.rd = r; x.wr = w; x.be = be;
      return x;
   endfunction

   function automatic req_t rand_req();
      req_t x;
      x.addr = $urandom;
      x.data = $urandom;
      x.wr   = 1'($urandom_range(0, 1));
      x.rd   = x.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      x.be   = x.wr ? 4'($urandom) : 4'hF;
      return x;
   endfunction

   task automatic check_all_zero(input string tag);
      chk_eq({tag, "_ctl"}, {m0_ready_out, m1_ready_out, m0_rdata_valid_out, m1_rdata_valid_out,
                             bus_err_out, ram_valid_out}, 72'h0);
      chk_eq({tag, "_rdata"}, {m0_read_data_out, m1_read_data_out}, 72'h0);
      chk_eq({tag, "_cmd"}, {ram_addr_out, ram_write_data_out, ram_read_en_out, ram_write_en_out,
                             ram_write_byte_en_out}, 72'h0);
   endtask

   // One clock cycle: drive masters and RAM, compare every output against the model,
   // then advance the model (acceptance takes effect at the next rising edge).
   task automatic step();
      req_t h0, h1, c;
      logic win, acc, exp_err, in_issue, in_wait;
      logic exp_rv[2];
      int   s, l, idx;
      bit   drp;
      @(negedge clk);
      cyc++;
      if (!pres[0] && q0.size() > 0 && $urandom_range(0, 99) >= gap_pct) pres[0] = 1'b1;
      if (!pres[1] && q1.size() > 0 && $urandom_range(0, 99) >= gap_pct) pres[1] = 1'b1;
      h0 = pres[0] ? q0[0] : '0;
      h1 = pres[1] ? q1[0] : '0;
      m0_valid_in = pres[0];
      m1_valid_in = pres[1];
      {m0_addr_in, m0_write_data_in, m0_read_en_in, m0_write_en_in, m0_write_byte_en_in} = h0;
      {m1_addr_in, m1_write_data_in, m1_read_en_in, m1_write_en_in, m1_write_byte_en_in} = h1;

      in_issue = t_valid && cyc >= t_iss_lo && cyc <= t_h;
      in_wait  = t_valid && !t_wr && cyc > t_h && cyc < t_resp;
      ram_ready_in = in_issue ? (cyc == t_h) : 1'($urandom_range(0, 1));
      if (in_wait && !t_drop && cyc == t_d) begin
         ram_rdata_valid_in = 1'b1;
         ram_read_data_in   = ram_mem[ram_addr_out[5:2]];
      end else begin
         ram_rdata_valid_in = !in_wait && (force_stray || $urandom_range(0, 7) == 0);
         ram_read_data_in   = $urandom;
      end
      force_stray = 0;
      #1;

      acc = (cyc >= free_cyc) && (pres[0] || pres[1]);
      win = (pres[0] && pres[1]) ? ~exp_last : pres[1];
      chk_eq("m0_ready", m0_ready_out, acc && win == 1'b0);
      chk_eq("m1_ready", m1_ready_out, acc && win == 1'b1);
      chk_eq("ram_valid", ram_valid_out, in_issue);
      chk_eq("ram_cmd", {ram_addr_out, ram_write_data_out, ram_read_en_out, ram_write_en_out,
                         ram_write_byte_en_out}, last_cmd);
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      exp_err   = 1'b0;
      if (t_valid && !t_wr && cyc == t_resp) begin
         exp_rv[t_owner] = 1'b1;
         exp_err         = t_drop;
         exp_rd[t_owner] = t_rdata;
      end
      chk_eq("m0_rdata_valid", m0_rdata_valid_out, exp_rv[0]);
      chk_eq("m1_rdata_valid", m1_rdata_valid_out, exp_rv[1]);
      chk_eq("bus_err", bus_err_out, exp_err);
      chk_eq("m0_read_data", m0_read_data_out, exp_rd[0]);
      chk_eq("m1_read_data", m1_read_data_out, exp_rd[1]);

      // the RAM commits a write on its handshake, using what the DUT presents
      if (ram_valid_out && ram_ready_in && ram_write_en_out) begin
         idx = int'(ram_addr_out[5:2]);
         ram_mem[idx] = (ram_mem[idx] & ~be_mask(ram_write_byte_en_out)) |
                        (ram_write_data_out & be_mask(ram_write_byte_en_out));
      end

      if (acc) begin
         c = win ? q1.pop_front() : q0.pop_front();
         pres[win] = 1'b0;
         exp_last  = win;
         last_cmd  = c;
         s   = (stall_force >= 0) ? stall_force : (quiet ? 0 : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0));
         l   = (lat_force >= 0) ? lat_force : (quiet ? 0 : $urandom_range(0, 2));
         drp = (drop_force >= 0) ? (drop_force != 0) : (!quiet && $urandom_range(0, 9) == 0);
         stall_force = -1; lat_force = -1; drop_force = -1;
         t_valid  = 1;
         t_owner  = win;
         t_wr     = c.wr;
         t_drop   = 0;
         t_iss_lo = cyc + 1;
         t_h      = cyc + 1 + s;
         idx      = int'(c.addr[5:2]);
         if (c.wr) begin
            ref_mem[idx] = (ref_mem[idx] & ~be_mask(c.be)) | (c.data & be_mask(c.be));
            free_cyc = t_h + 1;
         end else begin
            t_drop  = drp;
            t_rdata = drp ? 32'h0 : ref_mem[idx];
            if (drp) begin
               t_resp = t_h + TMO + 1;
            end else begin
               t_d    = t_h + 1 + l;
               t_resp = t_d + 1;
            end
            free_cyc = t_resp;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || cyc < free_cyc) && n < budget) begin
         step();
         n++;
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      pres[0] = 1'b0; pres[1] = 1'b0;
      exp_last = 1'b1;
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      last_cmd = '0;
      t_valid  = 0;
      free_cyc = 0;
   endtask

   task automatic reset_mid();
      @(negedge clk);
      cyc++;
      rst = 1'b1;
      m0_valid_in = 1'b0;
      m1_valid_in = 1'b0;
      ram_rdata_valid_in = 1'b1;
      ram_read_data_in   = 32'hDEAD_BEEF;
      #1;
      check_all_zero("reset_mid");
      model_reset();
      repeat (2) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b0;
      ram_rdata_valid_in = 1'b0;
      force_stray = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      {m0_valid_in, m0_addr_in, m0_write_data_in, m0_read_en_in, m0_write_en_in, m0_write_byte_en_in} = '0;
      {m1_valid_in, m1_addr_in, m1_write_data_in, m1_read_en_in, m1_write_en_in, m1_write_byte_en_in} = '0;
      ram_ready_in = 1'b0;
      ram_rdata_valid_in = 1'b0;
      ram_read_data_in = 32'h0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 32'h0;
         ram_mem[i] = 32'h0;
      end
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // first tie after reset goes to m0
      q0.push_back(mk(32'h10, 32'h0, 1'b1, 1'b0, 4'hF));
      q1.push_back(mk(32'h14, 32'h0, 1'b1, 1'b0, 4'hF));
      drain(200);

      // full-word write then read from m1, RAM idle
      q1.push_back(mk(32'h8, 32'hCAFE_BABE, 1'b0, 1'b1, 4'b1111));
      q1.push_back(mk(32'h8, 32'h0, 1'b1, 1'b0, 4'hF));
      drain(200);
      chk_eq("cafebabe_read", m1_read_data_out, 32'hCAFE_BABE);

      // both masters valid continuously: grants alternate
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk(32'h20 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 4'hF));
         q1.push_back(mk(32'h30 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 4'hF));
      end
      drain(400);

      // byte-lane write from m0 then read back
      q0.push_back(mk(32'h4, 32'h00AB_0000, 1'b0, 1'b1, 4'b0100));
      q0.push_back(mk(32'h4, 32'h0, 1'b1, 1'b0, 4'hF));
      drain(200);
      chk_eq("byte_write_read", m0_read_data_out, 32'h00AB_0000);

      // RAM stalls the command for three cycles
      stall_force = 3;
      q1.push_back(mk(32'h8, 32'h0, 1'b1, 1'b0, 4'hF));
      drain(200);

      // RAM never answers: timeout response, then stray late pulses
      drop_force = 1;
      q1.push_back(mk(32'h8, 32'h0, 1'b1, 1'b0, 4'hF));
      drain(200);
      chk_eq("timeout_data", m1_read_data_out, 32'h0);
      force_stray = 1; step();
      force_stray = 1; step();

      // reset while a read is waiting for data
      lat_force = 2;
      q0.push_back(mk(32'h8, 32'h0, 1'b1, 1'b0, 4'hF));
      repeat (3) step();
      reset_mid();
      repeat (4) step();
      q0.push_back(mk(32'h8, 32'h0, 1'b1, 1'b0, 4'hF));
      q1.push_back(mk(32'h4, 32'h0, 1'b1, 1'b0, 4'hF));
      drain(200);

      // randomized traffic with RAM stalls, latencies, timeouts and gaps
      quiet   = 0;
      gap_pct = 30;
      repeat (3000) begin
         if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
         if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
         step();
      end
      drain(2000);
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
